// File: rtl/dbus_router_if.sv
// Data-bus router interface: bundles the core-side (m_*) and slave-side (s_*) bus signals.
//   m_req/m_we/m_addr/m_wdata/m_be   core request fields
//   m_gnt/m_rsp_valid/m_rdata/m_err  router replies to the core
//   s_req (one per slave), s_we/s_addr/s_wdata/s_be broadcast fields
//   s_gnt (one per slave), s_rdata (NS packed DW-wide lanes)
// Modports:
//   slave  - the router's view (it serves the core and drives the slaves)
//   master - the environment's view (core plus slave models)
interface dbus_router_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned NS = 2
);
  logic             m_req;
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [DW/8-1:0]  m_be;
  logic             m_gnt;
  logic             m_rsp_valid;
  logic [DW-1:0]    m_rdata;
  logic             m_err;
  logic [NS-1:0]    s_req;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW/8-1:0]  s_be;
  logic [NS-1:0]    s_gnt;
  logic [NS*DW-1:0] s_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be, s_gnt, s_rdata,
    output m_gnt, m_rsp_valid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, s_be
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be, s_gnt, s_rdata,
    input  m_gnt, m_rsp_valid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, s_be
  );
endinterface

// File: rtl/dbus_router.sv
// Data-bus router: decodes each core load/store request by base/mask, forwards it to one of NS
// slaves and waits for that slave's grant. The response follows one cycle after the accept, with
// read data muxed from the slave captured in sel_q. Unmapped addresses are accepted at once and
// answered with an error.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active high
//   bus  - dbus_router_if.slave (core request/response and per-slave request/grant/read data)
// Compile option:
//   DBUS_TIMEOUT_EN - when defined, a request stalled for TO_CYC consecutive STALL cycles is
//                     aborted: s_req is dropped, m_gnt is raised and an error response follows.
module dbus_router #(
  parameter int unsigned      AW       = 32,
  parameter int unsigned      DW       = 32,
  parameter int unsigned      NS       = 2,
  parameter logic [NS*AW-1:0] SLV_BASE = {32'h1000, 32'h0},
  parameter logic [NS*AW-1:0] SLV_MASK = {2{32'hFFFFF000}},
  parameter int unsigned      TO_CYC   = 16
) (
  input logic          clk,
  input logic          rst,
  dbus_router_if.slave bus
);

  localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;

  if (NS < 1 || NS > 8) begin : g_ns_chk
    $error("dbus_router: NS must be in 1..8");
  end
  if (DW % 8 != 0) begin : g_dw_chk
    $error("dbus_router: DW must be a multiple of 8");
  end
  if (TO_CYC < 2) begin : g_to_chk
    $error("dbus_router: TO_CYC must be >= 2");
  end

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e        st_q;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_q;
  logic          hit;
  logic          unmapped;
  logic          abort;
  logic          accept;
  logic          we_q;
  logic          err_q;
  logic          rsp_q;
  logic [DW-1:0] rdata_sel;

  // Walk from the top index down so the lowest-index hit is the one that sticks.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end

  assign unmapped = ~hit;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYC + 1);
  // Number of STALL cycles already spent on the current request.
  logic [CW-1:0] cnt_q;
  assign abort = ~rst & bus.m_req & (st_q == StStall) & (cnt_q == CW'(TO_CYC - 1));
`else
  assign abort = 1'b0;
`endif

  // Reset gates the request/grant paths combinationally so nothing leaks out mid-reset.
  always_comb begin
    bus.s_req = '0;
    if (!rst && bus.m_req && hit && !abort) begin
      bus.s_req[sel] = 1'b1;
    end
  end

  assign accept    = ~rst & ((bus.m_req & unmapped) | (bus.s_gnt[sel] & bus.s_req[sel]) | abort);
  assign bus.m_gnt = accept;

  assign bus.s_we    = bus.m_we;
  assign bus.s_addr  = bus.m_addr;
  assign bus.s_wdata = bus.m_wdata;
  assign bus.s_be    = bus.m_be;

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q == SW'(i)) begin
        rdata_sel = bus.s_rdata[i*DW +: DW];
      end
    end
  end

  assign bus.m_rsp_valid = rsp_q;
  assign bus.m_err       = rsp_q & err_q;
  assign bus.m_rdata     = (rsp_q && !we_q && !err_q) ? rdata_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= StIdle;
      sel_q <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      rsp_q <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      rsp_q <= accept;
      if (accept) begin
        sel_q <= sel;
        we_q  <= bus.m_we;
        err_q <= unmapped | abort;
      end
      case (st_q)
        StIdle:  if (bus.m_req && !accept) st_q <= StStall;
        // Dropping m_req while stalled is a master violation; just fall back to idle.
        StStall: if (!bus.m_req || accept) st_q <= StIdle;
        default: st_q <= StIdle;
      endcase
`ifdef DBUS_TIMEOUT_EN
      if (st_q == StStall && bus.m_req && !accept) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dbus_router.sv
module tb_dbus_router;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned NS     = 2;
  localparam int unsigned TO_CYC = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dbus_router_if #(.AW(AW), .DW(DW), .NS(NS)) bus ();

  dbus_router #(
    .AW      (AW),
    .DW      (DW),
    .NS      (NS),
    .SLV_BASE({32'h1000, 32'h0}),
    .SLV_MASK({2{32'hFFFFF000}}),
    .TO_CYC  (TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference address map: slave i owns addr with (addr & 0xFFFFF000) == base[i], lowest wins.
  function automatic int decode(input logic [31:0] a);
    logic [31:0] base [2];
    base[0] = 32'h0000_0000;
    base[1] = 32'h0000_1000;
    for (int i = 0; i < 2; i++) begin
      if ((a & 32'hFFFF_F000) == base[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = $urandom;
    bus.m_wdata = $urandom;
    bus.m_be    = 4'($urandom);
    bus.s_gnt   = 2'($urandom);
    bus.s_rdata = {$urandom, $urandom};
  endtask

  task automatic set_req(input logic [31:0] addr, input logic we);
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = $urandom;
    bus.m_be    = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_req(32'h10, 1'b0);
    bus.s_gnt = 2'b11;
    #1;
    n_checks++; if (bus.m_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rst_gnt: got %b want 0", bus.m_gnt); end
    n_checks++; if (bus.s_req !== 2'b00) begin n_fail++;
      $display("FAIL rst_sreq: got %b want 00", bus.s_req); end
    tick();
    tick();
    n_checks++; if (bus.m_rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_rsp: got %b want 0", bus.m_rsp_valid); end
    n_checks++; if (bus.m_err !== 1'b0) begin n_fail++;
      $display("FAIL rst_err: got %b want 0", bus.m_err); end
    n_checks++; if (bus.m_rdata !== 32'h0) begin n_fail++;
      $display("FAIL rst_rdata: got %h want 0", bus.m_rdata); end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    idle_inputs();
    set_req(32'h0000_0010, 1'b0);
    bus.s_gnt = 2'b01;
    #1;
    n_checks++; if (bus.m_gnt !== 1'b1 || bus.s_req !== 2'b01) begin n_fail++;
      $display("FAIL rd_gnt: got gnt=%b sreq=%b want 1/01", bus.m_gnt, bus.s_req); end
    tick();
    idle_inputs();
    bus.s_rdata[31:0] = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (bus.m_rsp_valid !== 1'b1 || bus.m_rdata !== 32'hDEAD_BEEF || bus.m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rsp: got v=%b d=%h e=%b want 1/deadbeef/0",
               bus.m_rsp_valid, bus.m_rdata, bus.m_err);
    end
    tick();
    n_checks++; if (bus.m_rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rd_pulse: got %b want 0", bus.m_rsp_valid); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    set_req(32'h0000_1000, 1'b0);
    bus.s_gnt = 2'b10;
    #1;
    n_checks++; if (bus.m_gnt !== 1'b1 || bus.s_req !== 2'b10) begin n_fail++;
      $display("FAIL b2b_gnt1: got gnt=%b sreq=%b want 1/10", bus.m_gnt, bus.s_req); end
    tick();
    set_req(32'h0000_0004, 1'b0);
    bus.s_gnt = 2'b01;
    bus.s_rdata = {32'h0000_A5A5, 32'h0BAD_0BAD};
    #1;
    n_checks++; if (bus.m_gnt !== 1'b1 || bus.s_req !== 2'b01) begin n_fail++;
      $display("FAIL b2b_gnt2: got gnt=%b sreq=%b want 1/01", bus.m_gnt, bus.s_req); end
    n_checks++; if (bus.m_rsp_valid !== 1'b1 || bus.m_rdata !== 32'h0000_A5A5) begin n_fail++;
      $display("FAIL b2b_rsp1: got v=%b d=%h want 1/a5a5", bus.m_rsp_valid, bus.m_rdata); end
    tick();
    idle_inputs();
    bus.s_rdata = {32'h0BAD_0BAD, 32'h0000_1234};
    #1;
    n_checks++; if (bus.m_rsp_valid !== 1'b1 || bus.m_rdata !== 32'h0000_1234) begin n_fail++;
      $display("FAIL b2b_rsp2: got v=%b d=%h want 1/1234", bus.m_rsp_valid, bus.m_rdata); end
    tick();
  endtask

  task automatic test_unmapped_write();
    idle_inputs();
    set_req(32'h0000_2000, 1'b1);
    bus.s_gnt = 2'b11;
    #1;
    n_checks++; if (bus.m_gnt !== 1'b1 || bus.s_req !== 2'b00) begin n_fail++;
      $display("FAIL unm_gnt: got gnt=%b sreq=%b want 1/00", bus.m_gnt, bus.s_req); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.m_rsp_valid !== 1'b1 || bus.m_err !== 1'b1 || bus.m_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL unm_rsp: got v=%b e=%b d=%h want 1/1/0",
               bus.m_rsp_valid, bus.m_err, bus.m_rdata);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] v;
    v = $urandom;
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      set_req(32'h0000_0008, 1'b0);
      bus.s_gnt = (c == 3) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (bus.s_req !== 2'b01 || bus.m_gnt !== (c == 3) || bus.m_rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_c%0d: got sreq=%b gnt=%b v=%b want 01/%b/0",
                 c, bus.s_req, bus.m_gnt, bus.m_rsp_valid, (c == 3));
      end
      tick();
    end
    idle_inputs();
    bus.s_rdata[31:0] = v;
    #1;
    n_checks++;
    if (bus.m_rsp_valid !== 1'b1 || bus.m_rdata !== v || bus.m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rsp: got v=%b d=%h e=%b want 1/%h/0",
               bus.m_rsp_valid, bus.m_rdata, bus.m_err, v);
    end
    tick();
  endtask

  task automatic test_timeout();
`ifdef DBUS_TIMEOUT_EN
    for (int c = 0; c <= int'(TO_CYC); c++) begin
      idle_inputs();
      set_req(32'h0000_1000, 1'b0);
      bus.s_gnt = 2'b01;
      #1;
      n_checks++;
      if (bus.m_gnt !== (c == int'(TO_CYC)) ||
          bus.s_req !== ((c == int'(TO_CYC)) ? 2'b00 : 2'b10)) begin
        n_fail++;
        $display("FAIL to_c%0d: got gnt=%b sreq=%b want %b/%b", c, bus.m_gnt, bus.s_req,
                 (c == int'(TO_CYC)), ((c == int'(TO_CYC)) ? 2'b00 : 2'b10));
      end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++;
    if (bus.m_rsp_valid !== 1'b1 || bus.m_err !== 1'b1 || bus.m_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL to_rsp: got v=%b e=%b d=%h want 1/1/0",
               bus.m_rsp_valid, bus.m_err, bus.m_rdata);
    end
    tick();
`else
    int gnts;
    int bad_sreq;
    gnts = 0;
    bad_sreq = 0;
    for (int c = 0; c < 100; c++) begin
      idle_inputs();
      set_req(32'h0000_1000, 1'b0);
      bus.s_gnt = 2'b01;
      #1;
      if (bus.m_gnt !== 1'b0) gnts++;
      if (bus.s_req !== 2'b10) bad_sreq++;
      tick();
    end
    n_checks++; if (gnts !== 0) begin n_fail++;
      $display("FAIL to_nogrant: got %0d grants want 0", gnts); end
    n_checks++; if (bad_sreq !== 0) begin n_fail++;
      $display("FAIL to_sreq_held: got %0d bad cycles want 0", bad_sreq); end
    idle_inputs();
    tick();
    n_checks++; if (bus.m_rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL to_drop_rsp: got %b want 0", bus.m_rsp_valid); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    idle_inputs();
    set_req(32'h0000_0010, 1'b0);
    bus.s_gnt = 2'b01;
    #1;
    n_checks++; if (bus.m_gnt !== 1'b1) begin n_fail++;
      $display("FAIL rstm_gnt: got %b want 1", bus.m_gnt); end
    tick();
    rst = 1'b1;
    bus.s_gnt = 2'b11;
    #1;
    n_checks++;
    if (bus.m_rsp_valid !== 1'b0 || bus.m_rdata !== 32'h0 || bus.m_err !== 1'b0 ||
        bus.m_gnt !== 1'b0 || bus.s_req !== 2'b00) begin
      n_fail++;
      $display("FAIL rstm_clr: got v=%b d=%h e=%b gnt=%b sreq=%b want 0/0/0/0/00",
               bus.m_rsp_valid, bus.m_rdata, bus.m_err, bus.m_gnt, bus.s_req);
    end
    tick();
    n_checks++; if (bus.m_rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rstm_rsp: got %b want 0", bus.m_rsp_valid); end
    idle_inputs();
    rst = 1'b0;
    tick();
    v = $urandom;
    set_req(32'h0000_1020, 1'b0);
    bus.s_gnt = 2'b10;
    #1;
    n_checks++; if (bus.m_gnt !== 1'b1) begin n_fail++;
      $display("FAIL rstm_gnt2: got %b want 1", bus.m_gnt); end
    tick();
    idle_inputs();
    bus.s_rdata[63:32] = v;
    #1;
    n_checks++; if (bus.m_rsp_valid !== 1'b1 || bus.m_rdata !== v) begin n_fail++;
      $display("FAIL rstm_rsp2: got v=%b d=%h want 1/%h", bus.m_rsp_valid, bus.m_rdata, v); end
    tick();
  endtask

  task automatic test_random();
    logic        pend;
    logic        pend_rd;
    logic        pend_err;
    int          pend_slv;
    logic [31:0] pend_data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        we;
    logic        exp_gnt;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_sreq;
    int          exp_slv;
    int          delay;
    int          c;
    bit          done;
    pend = 1'b0;
    pend_rd = 1'b0;
    pend_err = 1'b0;
    pend_slv = 0;
    pend_data = '0;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_inputs();
        if (pend && pend_rd) bus.s_rdata[pend_slv*32 +: 32] = pend_data;
        #1;
        exp_rdata = (pend && pend_rd) ? pend_data : 32'h0;
        n_checks++;
        if (bus.m_rsp_valid !== pend || bus.m_err !== (pend && pend_err) ||
            bus.m_rdata !== exp_rdata || bus.m_gnt !== 1'b0 || bus.s_req !== 2'b00) begin
          n_fail++;
          $display("FAIL rnd_idle t=%0d: got v=%b e=%b d=%h g=%b s=%b want %b/%b/%h/0/00", t,
                   bus.m_rsp_valid, bus.m_err, bus.m_rdata, bus.m_gnt, bus.s_req,
                   pend, (pend && pend_err), exp_rdata);
        end
        tick();
        pend = 1'b0;
      end
      case ($urandom_range(0, 2))
        0:       addr = {20'h00000, 12'($urandom)};
        1:       addr = {20'h00001, 12'($urandom)};
        default: addr = {20'($urandom_range(2, 32'hFFFFF)), 12'($urandom)};
      endcase
      we = 1'($urandom);
      wdata = $urandom;
      be = 4'($urandom);
      rd = $urandom;
      delay = $urandom_range(0, 3);
      exp_slv = decode(addr);
      exp_sreq = (exp_slv < 0) ? 2'b00 : 2'(1 << exp_slv);
      c = 0;
      done = 1'b0;
      while (!done) begin
        bus.m_req = 1'b1;
        bus.m_we = we;
        bus.m_addr = addr;
        bus.m_wdata = wdata;
        bus.m_be = be;
        bus.s_gnt = 2'($urandom);
        if (exp_slv >= 0) bus.s_gnt[exp_slv] = (c == delay);
        bus.s_rdata = {$urandom, $urandom};
        if (pend && pend_rd) bus.s_rdata[pend_slv*32 +: 32] = pend_data;
        #1;
        exp_rdata = (pend && pend_rd) ? pend_data : 32'h0;
        n_checks++;
        if (bus.m_rsp_valid !== pend || bus.m_err !== (pend && pend_err) ||
            bus.m_rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL rnd_rsp t=%0d c=%0d: got v=%b e=%b d=%h want %b/%b/%h", t, c,
                   bus.m_rsp_valid, bus.m_err, bus.m_rdata, pend, (pend && pend_err), exp_rdata);
        end
        exp_gnt = (exp_slv < 0) || (c == delay);
        n_checks++;
        if (bus.m_gnt !== exp_gnt || bus.s_req !== exp_sreq) begin
          n_fail++;
          $display("FAIL rnd_req t=%0d c=%0d addr=%h: got g=%b s=%b want %b/%b", t, c, addr,
                   bus.m_gnt, bus.s_req, exp_gnt, exp_sreq);
        end
        n_checks++;
        if (bus.s_addr !== addr || bus.s_we !== we || bus.s_wdata !== wdata || bus.s_be !== be)
        begin
          n_fail++;
          $display("FAIL rnd_bcast t=%0d: got a=%h w=%b d=%h b=%h want %h/%b/%h/%h", t,
                   bus.s_addr, bus.s_we, bus.s_wdata, bus.s_be, addr, we, wdata, be);
        end
        tick();
        if (exp_gnt) begin
          pend = 1'b1;
          pend_rd = !we && (exp_slv >= 0);
          pend_err = (exp_slv < 0);
          pend_slv = (exp_slv < 0) ? 0 : exp_slv;
          pend_data = rd;
          done = 1'b1;
        end else begin
          pend = 1'b0;
        end
        c++;
        if (!done && c > 8) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_bound t=%0d: got no grant after %0d cycles want grant", t, c);
          done = 1'b1;
        end
      end
    end
    idle_inputs();
    if (pend && pend_rd) bus.s_rdata[pend_slv*32 +: 32] = pend_data;
    #1;
    exp_rdata = (pend && pend_rd) ? pend_data : 32'h0;
    n_checks++;
    if (bus.m_rsp_valid !== pend || bus.m_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL rnd_tail: got v=%b d=%h want %b/%h", bus.m_rsp_valid, bus.m_rdata,
               pend, exp_rdata);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_unmapped_write();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
